// File: rtl/spi_pkg.sv
// Definitions shared by the SPI peripheral and its controller: FSM state encoding and
// mode-0 clock polarity/phase constants.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by one extra flop that
// provides single-cycle rise/fall strobes of the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus the delayed copy used for edge detection
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_r <= {STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], async_i};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign sync_o = sync_r[STAGES-1];
  assign rise_o = sync_r[STAGES-1] & ~prev_r;
  assign fall_o = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: MSB-first full-duplex frames of FRAME_WIDTH bits, oversampled by clk_i.
// Define SPI_PERIPHERAL_ERROR_EN to report short/long frames on frame_error_o.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int FRAME_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   spi_sclk_i,
  input  logic                   spi_mosi_i,
  input  logic                   spi_cs_i,
  output logic                   spi_miso_o,
  output logic                   spi_miso_oe_o,
  input  logic [FRAME_WIDTH-1:0] data_i,
  output logic [FRAME_WIDTH-1:0] data_o,
  output logic                   valid_o,
  output logic                   frame_error_o,
  output logic                   is_idle_o
);

  localparam int CW = $clog2(FRAME_WIDTH + 2);
  localparam logic [CW-1:0] FW_C    = CW'(FRAME_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_WIDTH + 1);

  state_t                 state_r;
  state_t                 state_next;
  logic [CW-1:0]          count_r;
  logic [FRAME_WIDTH-1:0] tx_r;
  logic [FRAME_WIDTH-1:0] rx_r;
  logic [FRAME_WIDTH-1:0] data_r;
  logic                   valid_r;
  logic                   frame_ok;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;
  logic sclk_level_unused, cs_level_unused, mosi_rise_unused, mosi_fall_unused;
  logic sample_edge, shift_edge;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sclk_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (spi_sclk_i),
    .sync_o  (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // cs resets high so a /CS held low across reset release yields a fresh frame start
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (spi_cs_i),
    .sync_o  (cs_level_unused),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (spi_mosi_i),
    .sync_o  (mosi_sync),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  assign sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
  assign shift_edge  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;
  assign frame_ok    = (count_r == FW_C);

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall) state_next = SHIFT;
        else         state_next = IDLE;
      end
      SHIFT: begin
        if (cs_rise) state_next = DONE;
        else         state_next = SHIFT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter and received-word capture
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_r <= '0;
      tx_r    <= '0;
      rx_r    <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_r    <= data_i;
          count_r <= '0;
        end
        SHIFT: begin
          // A cs rise wins over any sclk edge seen in the same cycle
          if (!cs_rise) begin
            if (sample_edge) begin
              rx_r <= {rx_r[FRAME_WIDTH-2:0], mosi_sync};
              if (count_r != CNT_MAX) count_r <= count_r + CW'(1);
            end
            if (shift_edge && (count_r < FW_C)) begin
              tx_r <= {tx_r[FRAME_WIDTH-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (frame_ok) begin
            data_r  <= rx_r;
            valid_r <= 1'b1;
          end
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

`ifdef SPI_PERIPHERAL_ERROR_EN
  logic error_r;

  // Flag frames that ended with a bit count other than FRAME_WIDTH
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      error_r <= 1'b0;
    end else begin
      error_r <= (state_r == DONE) && !frame_ok;
    end
  end

  assign frame_error_o = error_r;
`else
  assign frame_error_o = 1'b0;
`endif

  assign data_o        = data_r;
  assign valid_o       = valid_r;
  assign spi_miso_oe_o = (state_r == SHIFT);
  assign spi_miso_o    = (state_r == SHIFT) & tx_r[FRAME_WIDTH-1];
  assign is_idle_o     = (state_r == IDLE);

endmodule
